io_channel_unit: RTL and testbench
==================================

IO_CHANNEL_UNIT -- requirements
Module: io_channel_unit

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, output-FIFO entries (power of two, 2..16).
REQ-002 SHALL have port: clock  input  1  system clock.
REQ-003 SHALL have port: rst_l  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: IO_write_en  input  1  core writeback-stage channel write strobe.
REQ-005 SHALL have port: IO_write_sel  input  4  core write channel number.
REQ-006 SHALL have port: IO_write_data  input  15  core write word.
REQ-007 SHALL have port: IO_read_sel  input  4  core decode-stage read channel number.
REQ-008 SHALL have port: IO_read_data  output  15  channel word returned to core.
REQ-009 SHALL have port: ext_in_valid  input  1  peripheral input-word strobe.
REQ-010 SHALL have port: ext_in_sel  input  3  input channel 0-7 being written.
REQ-011 SHALL have port: ext_in_data  input  15  peripheral input word.
REQ-012 SHALL have port: ext_in_ready  output  1  input word accepted this cycle.
REQ-013 SHALL have port: ext_out_valid  output  1  output FIFO head valid.
REQ-014 SHALL have port: ext_out_sel  output  4  head entry channel number (8-15).
REQ-015 SHALL have port: ext_out_data  output  15  head entry word.
REQ-016 SHALL have port: ext_out_ready  input  1  peripheral consumes head.
REQ-017 SHALL have port: fifo_count  output  5  FIFO occupancy.
REQ-018 SHALL have port: io_full  output  1  FIFO full.
REQ-019 SHALL have port: io_overflow  output  1  sticky: an output write was dropped.

Function
REQ-020 SHALL hold sixteen 15-bit channel registers; 0-7 input channels, 8-15 output channels.
REQ-021 SHALL update a channel register on the clock edge ending the cycle in which a core write to it is accepted.
REQ-022 SHALL drive IO_read_data combinationally from the register selected by IO_read_sel, bypassing IO_write_data when IO_write_en and IO_write_sel equal IO_read_sel in the same cycle.
REQ-023 SHALL enqueue {IO_write_sel, IO_write_data} on every accepted core write to channels 8-15; writes to channels 0-7 update the register only.
REQ-024 SHALL accept an output-channel write when FIFO not full, or when full and ext_out_valid and ext_out_ready pop in the same cycle.
REQ-025 SHALL, on an output-channel write while full without a same-cycle pop, drop the write entirely (register and FIFO unchanged) and set io_overflow.
REQ-026 SHALL present FIFO head on ext_out_sel/ext_out_data with ext_out_valid = (fifo_count != 0); head stable until popped.
REQ-027 SHALL pop one entry per cycle when ext_out_valid and ext_out_ready; ext_out_ready while empty has no effect.
REQ-028 SHALL keep fifo_count exact under simultaneous push and pop (unchanged) and wrap read/write pointers modulo FIFO_DEPTH.
REQ-029 SHALL drive ext_in_ready high except in a cycle where IO_write_en targets channel {1'b0, ext_in_sel}; core write wins that cycle.
REQ-030 SHALL write ext_in_data to input channel ext_in_sel on the edge when ext_in_valid and ext_in_ready.
REQ-031 SHALL assert io_full combinationally when fifo_count equals FIFO_DEPTH.

Reset
REQ-032 SHALL, on rst_l low, asynchronously clear all channel registers, FIFO pointers, fifo_count and io_overflow; ext_out_valid and io_full read 0.
REQ-033 SHALL discard FIFO contents on reset mid-operation; io_overflow clears only on reset.

Configuration
REQ-034 SHALL, with IO_LOOPBACK_EN defined, write each popped entry's data into input channel (ext_out_sel - 8) on the pop edge, unless ext_in or a core write targets that channel the same cycle (priority: core, ext_in, loopback).
REQ-035 SHALL, without IO_LOOPBACK_EN, leave input channels unaffected by pops.

Structure
REQ-036 SHALL take IO_CHANNELS (16), IO_OUT_BASE (8), io_word_t (15-bit) and io_entry_t ({sel, data}) from a shared package io_pkg.
REQ-037 SHALL instantiate one sub-module io_out_fifo (parameterised synchronous FIFO with count).

Verification
REQ-038 SHALL cover: core write ch 3 = 'o12345 -> next cycle IO_read_sel=3 returns 'o12345; FIFO count stays 0.
REQ-039 SHALL cover: same-cycle write/read ch 9 = 'o777 -> IO_read_data='o777 combinationally; ext_out_valid high next cycle with sel 9.
REQ-040 SHALL cover: 5 writes to ch 10 with ext_out_ready=0, depth 4 -> fifo_count=4, io_full=1, 5th dropped, io_overflow=1, ch 10 holds 4th value.
REQ-041 SHALL cover: full FIFO, ext_out_ready=1 plus core write ch 11 same cycle -> accepted, count stays 4, io_overflow stays 0.
REQ-042 SHALL cover: ext_in ch 2 = 'o1 and core write ch 2 = 'o2 same cycle -> ext_in_ready=0, ch 2 = 'o2.
REQ-043 SHALL cover: IO_LOOPBACK_EN, pop entry {ch 12, 'o4321} -> ch 4 reads 'o4321 next cycle; rst_l low mid-stream -> all outputs 0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared definitions for the IO channel unit.
// Provides the channel count, the first output channel number, the channel
// word type and the output-FIFO entry type ({channel number, word}).
package io_pkg;

  localparam int unsigned IO_CHANNELS = 16;
  localparam int unsigned IO_OUT_BASE = 8;

  typedef logic [14:0] io_word_t;

  typedef struct packed {
    logic [3:0] sel;
    io_word_t   data;
  } io_entry_t;

endpackage

// File: rtl/io_out_fifo.sv
// Synchronous FIFO with an exact occupancy count, holding output-channel writes.
// Ports:
//   clock, rst_l     clock and asynchronous active-low reset
//   push, push_data  enqueue request and entry (taken if not full, or full with pop)
//   pop              dequeue request (ignored while empty)
//   head             entry at the read pointer (meaningful only when !empty)
//   count            occupancy, 0..DEPTH
//   full, empty      occupancy flags
module io_out_fifo
  import io_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clock,
  input  logic      rst_l,
  input  logic      push,
  input  io_entry_t push_data,
  input  logic      pop,
  output io_entry_t head,
  output logic [4:0] count,
  output logic      full,
  output logic      empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  io_entry_t       mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [4:0]      count_q;
  logic            do_push, do_pop;

  assign empty   = (count_q == 5'd0);
  assign full    = (count_q == 5'(DEPTH));
  assign do_pop  = pop && !empty;
  // When full, the slot being popped this cycle is the one the push lands in.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // DEPTH is a power of two, so pointers wrap naturally at PtrW bits.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 5'd1;
      else if (do_pop && !do_push) count_q <= count_q - 5'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/io_channel_unit.sv
// IO channel unit: sixteen 15-bit channel registers (0-7 input, 8-15 output)
// shared between the core and peripherals. Core writes to output channels are
// also queued in an output FIFO for the peripheral side.
// Ports:
//   clock, rst_l                         clock, asynchronous active-low reset
//   IO_write_en/sel/data                 core channel write
//   IO_read_sel, IO_read_data            core channel read (write-bypassed)
//   ext_in_valid/sel/data, ext_in_ready  peripheral write to input channels
//   ext_out_valid/sel/data, ext_out_ready output FIFO head and pop
//   fifo_count, io_full, io_overflow     FIFO status; overflow is sticky
// Build option: define IO_LOOPBACK_EN to copy each popped entry's word into
// input channel (sel - 8), lowest priority behind core and ext_in writes.
module io_channel_unit
  import io_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clock,
  input  logic        rst_l,
  input  logic        IO_write_en,
  input  logic [3:0]  IO_write_sel,
  input  logic [14:0] IO_write_data,
  input  logic [3:0]  IO_read_sel,
  output logic [14:0] IO_read_data,
  input  logic        ext_in_valid,
  input  logic [2:0]  ext_in_sel,
  input  logic [14:0] ext_in_data,
  output logic        ext_in_ready,
  output logic        ext_out_valid,
  output logic [3:0]  ext_out_sel,
  output logic [14:0] ext_out_data,
  input  logic        ext_out_ready,
  output logic [4:0]  fifo_count,
  output logic        io_full,
  output logic        io_overflow
);

  io_word_t  chan_q [IO_CHANNELS];
  io_word_t  chan_d [IO_CHANNELS];
  io_entry_t head;
  logic      fifo_empty;
  logic      out_wr, pop, core_acc, in_acc, overflow_q;

  assign out_wr   = IO_write_en && (IO_write_sel >= 4'(IO_OUT_BASE));
  assign pop      = ext_out_valid && ext_out_ready;
  // A write to a full FIFO is still taken if the head leaves in the same cycle.
  assign core_acc = IO_write_en && (!out_wr || !io_full || pop);

  assign ext_in_ready = !(IO_write_en && (IO_write_sel == {1'b0, ext_in_sel}));
  assign in_acc       = ext_in_valid && ext_in_ready;

  assign IO_read_data = (IO_write_en && (IO_write_sel == IO_read_sel)) ? IO_write_data
                                                                       : chan_q[IO_read_sel];

  io_out_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .clock     (clock),
    .rst_l     (rst_l),
    .push      (out_wr && core_acc),
    .push_data ('{sel: IO_write_sel, data: IO_write_data}),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count),
    .full      (io_full),
    .empty     (fifo_empty)
  );

  assign ext_out_valid = !fifo_empty;
  // Masked while empty so stale memory never reaches the pins.
  assign ext_out_sel   = ext_out_valid ? head.sel  : '0;
  assign ext_out_data  = ext_out_valid ? head.data : '0;
  assign io_overflow   = overflow_q;

  // Later assignments win: loopback < ext_in < core.
  always_comb begin
    for (int i = 0; i < int'(IO_CHANNELS); i++) chan_d[i] = chan_q[i];
`ifdef IO_LOOPBACK_EN
    if (pop) chan_d[4'(head.sel - 4'(IO_OUT_BASE))] = head.data;
`else
    // Pops leave the input channels untouched.
`endif
    if (in_acc)   chan_d[{1'b0, ext_in_sel}] = ext_in_data;
    if (core_acc) chan_d[IO_write_sel]       = IO_write_data;
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < int'(IO_CHANNELS); i++) chan_q[i] <= '0;
      overflow_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(IO_CHANNELS); i++) chan_q[i] <= chan_d[i];
      if (out_wr && !core_acc) overflow_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_io_channel_unit.sv
// Self-checking bench for io_channel_unit: directed scenarios followed by
// random traffic, all compared against a queue/array reference model.
module tb_io_channel_unit;

  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        rst_l = 1'b0;
  logic        IO_write_en = 1'b0;
  logic [3:0]  IO_write_sel = '0;
  logic [14:0] IO_write_data = '0;
  logic [3:0]  IO_read_sel = '0;
  logic [14:0] IO_read_data;
  logic        ext_in_valid = 1'b0;
  logic [2:0]  ext_in_sel = '0;
  logic [14:0] ext_in_data = '0;
  logic        ext_in_ready;
  logic        ext_out_valid;
  logic [3:0]  ext_out_sel;
  logic [14:0] ext_out_data;
  logic        ext_out_ready = 1'b0;
  logic [4:0]  fifo_count;
  logic        io_full;
  logic        io_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [14:0] m_regs [16];
  logic [3:0]  q_sel [$];
  logic [14:0] q_dat [$];
  bit          m_ovf;

  io_channel_unit #(
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock         (clock),
    .rst_l         (rst_l),
    .IO_write_en   (IO_write_en),
    .IO_write_sel  (IO_write_sel),
    .IO_write_data (IO_write_data),
    .IO_read_sel   (IO_read_sel),
    .IO_read_data  (IO_read_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_sel    (ext_in_sel),
    .ext_in_data   (ext_in_data),
    .ext_in_ready  (ext_in_ready),
    .ext_out_valid (ext_out_valid),
    .ext_out_sel   (ext_out_sel),
    .ext_out_data  (ext_out_data),
    .ext_out_ready (ext_out_ready),
    .fifo_count    (fifo_count),
    .io_full       (io_full),
    .io_overflow   (io_overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    q_sel.delete();
    q_dat.delete();
    m_ovf = 1'b0;
  endtask

  // Compare every output against what the model predicts for the current inputs.
  task automatic check_model();
    logic [14:0] exp_rd;
    bit          bypass;
    bypass = IO_write_en && (IO_write_sel == IO_read_sel);
    exp_rd = bypass ? IO_write_data : m_regs[IO_read_sel];
    check("read_data", IO_read_data, exp_rd);
    check("ext_in_ready", ext_in_ready,
          !(IO_write_en && (int'(IO_write_sel) == int'(ext_in_sel))));
    check("out_valid", ext_out_valid, q_sel.size() != 0);
    check("out_sel", ext_out_sel, (q_sel.size() != 0) ? q_sel[0] : 4'd0);
    check("out_data", ext_out_data, (q_dat.size() != 0) ? q_dat[0] : 15'd0);
    check("count", fifo_count, q_sel.size());
    check("full", io_full, q_sel.size() == DEPTH);
    check("overflow", io_overflow, m_ovf);
  endtask

  task automatic step(input bit en, input int wsel, input int wdata, input int rsel,
                      input bit iv, input int isel, input int idata, input bit ordy);
    IO_write_en   = en;
    IO_write_sel  = 4'(wsel);
    IO_write_data = 15'(wdata);
    IO_read_sel   = 4'(rsel);
    ext_in_valid  = iv;
    ext_in_sel    = 3'(isel);
    ext_in_data   = 15'(idata);
    ext_out_ready = ordy;
    #3;
    check_model();
  endtask

  // Advance one clock edge and apply the architectural rules to the model.
  task automatic tick();
    bit          popped, in_ok;
    logic [3:0]  hs;
    logic [14:0] hd;
    int          lb_ch;
    popped = (q_sel.size() != 0) && ext_out_ready;
    hs = '0;
    hd = '0;
    if (popped) begin
      hs = q_sel.pop_front();
      hd = q_dat.pop_front();
    end
    in_ok = ext_in_valid && !(IO_write_en && (int'(IO_write_sel) == int'(ext_in_sel)));
    if (in_ok) m_regs[ext_in_sel] = ext_in_data;
    if (IO_write_en) begin
      if (IO_write_sel < 8) begin
        m_regs[IO_write_sel] = IO_write_data;
      end else if (q_sel.size() < DEPTH) begin
        m_regs[IO_write_sel] = IO_write_data;
        q_sel.push_back(IO_write_sel);
        q_dat.push_back(IO_write_data);
      end else begin
        m_ovf = 1'b1;
      end
    end
`ifdef IO_LOOPBACK_EN
    if (popped) begin
      lb_ch = int'(hs) - 8;
      if (!(IO_write_en && int'(IO_write_sel) == lb_ch) && !(in_ok && int'(ext_in_sel) == lb_ch))
        m_regs[lb_ch] = hd;
    end
`else
    lb_ch = 0;
`endif
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int rsel);
    step(0, 0, 0, rsel, 0, 0, 0, 0);
  endtask

  // Asynchronous reset asserted between edges; outputs must clear immediately.
  task automatic do_reset();
    IO_write_en = 0; ext_in_valid = 0; ext_out_ready = 0; IO_read_sel = 4'd9;
    rst_l = 1'b0;
    #2;
    check("rst_read", IO_read_data, 0);
    check("rst_valid", ext_out_valid, 0);
    check("rst_sel", ext_out_sel, 0);
    check("rst_data", ext_out_data, 0);
    check("rst_count", fifo_count, 0);
    check("rst_full", io_full, 0);
    check("rst_ovf", io_overflow, 0);
    model_clear();
    rst_l = 1'b1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    model_clear();
    #3;
    check("init_count", fifo_count, 0);
    check("init_valid", ext_out_valid, 0);
    check("init_ovf", io_overflow, 0);
    @(posedge clock);
    #1;
    rst_l = 1'b1;

    // Input-channel core write: register only, FIFO untouched.
    step(1, 3, 'o12345, 0, 0, 0, 0, 0); tick();
    idle(3);
    check("ch3_read", IO_read_data, 'o12345);
    check("ch3_count", fifo_count, 0);
    tick();

    // Same-cycle write/read bypass on an output channel.
    step(1, 9, 'o777, 9, 0, 0, 0, 0);
    check("ch9_bypass", IO_read_data, 'o777);
    tick();
    idle(0);
    check("ch9_valid", ext_out_valid, 1);
    check("ch9_sel", ext_out_sel, 9);
    tick();
    step(0, 0, 0, 0, 0, 0, 0, 1); tick();

    // Overfill: fifth write dropped, overflow sticks.
    for (int i = 1; i <= 5; i++) begin
      step(1, 10, i, 0, 0, 0, 0, 0);
      if (i == 5) begin
        check("fill_count", fifo_count, 4);
        check("fill_full", io_full, 1);
      end
      tick();
    end
    idle(10);
    check("drop_ch10", IO_read_data, 4);
    check("drop_ovf", io_overflow, 1);
    check("drop_count", fifo_count, 4);
    tick();

    // Full FIFO with simultaneous pop and push.
    do_reset();
    for (int i = 1; i <= 4; i++) begin step(1, 10, i, 0, 0, 0, 0, 0); tick(); end
    step(1, 11, 'o11, 0, 0, 0, 0, 1); tick();
    idle(11);
    check("pp_count", fifo_count, 4);
    check("pp_ovf", io_overflow, 0);
    check("pp_head", ext_out_data, 2);
    check("pp_ch11", IO_read_data, 'o11);
    tick();
    for (int i = 0; i < 4; i++) begin step(0, 0, 0, 0, 0, 0, 0, 1); tick(); end

    // Core write beats ext_in on the same input channel.
    step(1, 2, 'o2, 0, 1, 2, 'o1, 0);
    check("conflict_ready", ext_in_ready, 0);
    tick();
    idle(2);
    check("conflict_ch2", IO_read_data, 'o2);
    tick();

    // Pop of a channel-12 entry: loopback into ch 4 only when enabled.
    do_reset();
    step(1, 12, 'o4321, 0, 0, 0, 0, 0); tick();
    step(0, 0, 0, 4, 0, 0, 0, 1); tick();
    idle(4);
`ifdef IO_LOOPBACK_EN
    check("loopback_ch4", IO_read_data, 'o4321);
`else
    check("no_loopback_ch4", IO_read_data, 0);
`endif
    tick();

    // Random traffic, with one reset in the middle of the stream.
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      step($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 32767),
           $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 32767), $urandom_range(0, 3) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
